// File: rtl/output_compare_if.sv
// Bus bundle for one output-compare channel: counter feed, register
// write port, flag clear and the channel outputs.
interface output_compare_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_module_en;
    logic [CNT_W-1:0] i_cnt_data;
    logic             i_cnt_ovf_flg;
    logic             i_wr_cmp;
    logic             i_wr_ctrl;
    logic [CNT_W-1:0] i_wr_data;
    logic             i_flg_clr;
    logic             o_out_pin;
    logic             o_cmp_flg;
    logic             o_cmp_pending;
    logic [CNT_W-1:0] o_cmp_val;

    // Driver side: counter source and register writer
    modport master (
        output i_module_en, i_cnt_data, i_cnt_ovf_flg,
        output i_wr_cmp, i_wr_ctrl, i_wr_data, i_flg_clr,
        input  o_out_pin, o_cmp_flg, o_cmp_pending, o_cmp_val
    );

    // Compare channel side
    modport slave (
        input  i_module_en, i_cnt_data, i_cnt_ovf_flg,
        input  i_wr_cmp, i_wr_ctrl, i_wr_data, i_flg_clr,
        output o_out_pin, o_cmp_flg, o_cmp_pending, o_cmp_val
    );
endinterface

// File: rtl/output_compare.sv
// Single output-compare channel: compare register with optional
// overflow-synchronised preload, edge-detected match events driving
// set/clear/toggle/frozen pin actions, PWM mode and a sticky match flag.
module output_compare #(
    parameter int unsigned CNT_W = 16
) (
    input  logic           i_sysclk,
    input  logic           i_sysrst,
    output_compare_if.slave bus
);

    logic [4:0]       r_ctrl;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_pin;
    logic             r_flg;
    logic             r_match_d;

    logic [1:0]       w_mode;
    logic             w_pwm_en;
    logic             w_pol_inv;
    logic             w_preload;
    logic             w_match;
    logic             w_event;

    assign w_mode    = r_ctrl[1:0];
    assign w_pwm_en  = r_ctrl[2];
    assign w_pol_inv = r_ctrl[3];
    assign w_preload = r_ctrl[4];

    assign w_match = (bus.i_cnt_data == r_active);
    assign w_event = w_match & ~r_match_d & bus.i_module_en;

    // Control register write
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            r_ctrl <= '0;
        end else if (bus.i_wr_ctrl) begin
            r_ctrl <= bus.i_wr_data[4:0];
        end
    end

    // Active/shadow compare registers; a write coinciding with an overflow
    // transfers the old shadow while the new data stays pending
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (bus.i_cnt_ovf_flg && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (bus.i_wr_cmp) begin
                if (w_preload) begin
                    r_shadow  <= bus.i_wr_data;
                    r_pending <= 1'b1;
                end else begin
                    r_active  <= bus.i_wr_data;
                end
            end
        end
    end

    // Registered match for edge detection; forced low while disabled so
    // enabling inside equality yields an event
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            r_match_d <= 1'b0;
        end else begin
            r_match_d <= w_match & bus.i_module_en;
        end
    end

    // Internal pin state: PWM level every enabled cycle, else mode action on events
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            r_pin <= 1'b0;
        end else if (bus.i_module_en) begin
            if (w_pwm_en) begin
                r_pin <= (r_active > bus.i_cnt_data);
            end else if (w_event) begin
                case (w_mode)
                    2'b01:   r_pin <= 1'b1;
                    2'b10:   r_pin <= 1'b0;
                    2'b11:   r_pin <= ~r_pin;
                    default: r_pin <= r_pin;
                endcase
            end
        end
    end

    // Sticky match flag; a match event beats a simultaneous clear
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            r_flg <= 1'b0;
        end else if (w_event) begin
            r_flg <= 1'b1;
        end else if (bus.i_flg_clr && bus.i_module_en) begin
            r_flg <= 1'b0;
        end
    end

    // Output drive
    always_comb begin
        bus.o_out_pin     = r_pin ^ w_pol_inv;
        bus.o_cmp_flg     = r_flg;
        bus.o_cmp_pending = r_pending;
        bus.o_cmp_val     = r_active;
    end

endmodule

// File: tb/tb_output_compare.sv
// Directed bench for output_compare: reset, toggle, preload, PWM,
// flag collision, enable/equality and mid-operation reset.
module tb_output_compare;

    localparam int unsigned CNT_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    output_compare_if #(.CNT_W(CNT_W)) bus ();

    output_compare #(.CNT_W(CNT_W)) u_dut (
        .i_sysclk (clk),
        .i_sysrst (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_ctrl(input logic [CNT_W-1:0] v);
        bus.i_wr_ctrl = 1'b1;
        bus.i_wr_data = v;
        tick();
        bus.i_wr_ctrl = 1'b0;
    endtask

    task automatic write_cmp(input logic [CNT_W-1:0] v);
        bus.i_wr_cmp  = 1'b1;
        bus.i_wr_data = v;
        tick();
        bus.i_wr_cmp  = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_module_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic exp_pin;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.i_module_en   = 1'b0;
        bus.i_cnt_data    = '0;
        bus.i_cnt_ovf_flg = 1'b0;
        bus.i_wr_cmp      = 1'b0;
        bus.i_wr_ctrl     = 1'b0;
        bus.i_wr_data     = '0;
        bus.i_flg_clr     = 1'b0;

        // Reset state
        ticks(2);
        rst_n = 1'b1;
        check("rst_pin", bus.o_out_pin, 0);
        check("rst_flg", bus.o_cmp_flg, 0);
        check("rst_pend", bus.o_cmp_pending, 0);
        check("rst_val", bus.o_cmp_val, 0);

        // Toggle mode: ctrl=0x03, cmp=5, count 0..9 twice
        write_ctrl(16'h0003);
        write_cmp(16'h0005);
        check("tog_val", bus.o_cmp_val, 16'h0005);
        bus.i_module_en = 1'b1;
        exp_pin = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 10; k++) begin
                bus.i_cnt_data = CNT_W'(k);
                tick();
                if (k == 5) exp_pin = ~exp_pin;
                if (k >= 4 && k <= 6) check("tog_pin", bus.o_out_pin, exp_pin);
            end
        end
        check("tog_pin_end", bus.o_out_pin, 0);
        check("tog_flg", bus.o_cmp_flg, 1);
        bus.i_flg_clr = 1'b1;
        tick();
        bus.i_flg_clr = 1'b0;
        check("tog_flg_clr", bus.o_cmp_flg, 0);

        // Preload: active=0x10, write 0x20 mid-period, transfer on overflow
        do_reset();
        bus.i_cnt_data = '0;
        write_ctrl(16'h0001);
        write_cmp(16'h0010);
        write_ctrl(16'h0011);
        write_cmp(16'h0020);
        check("pre_pend", bus.o_cmp_pending, 1);
        check("pre_val_hold", bus.o_cmp_val, 16'h0010);
        ticks(3);
        check("pre_val_hold2", bus.o_cmp_val, 16'h0010);
        bus.i_cnt_ovf_flg = 1'b1;
        tick();
        bus.i_cnt_ovf_flg = 1'b0;
        check("pre_val_xfer", bus.o_cmp_val, 16'h0020);
        check("pre_pend_clr", bus.o_cmp_pending, 0);
        // Write coinciding with overflow: old shadow transfers, new stays pending
        write_cmp(16'h0030);
        bus.i_cnt_ovf_flg = 1'b1;
        write_cmp(16'h0040);
        bus.i_cnt_ovf_flg = 1'b0;
        check("col_val", bus.o_cmp_val, 16'h0030);
        check("col_pend", bus.o_cmp_pending, 1);
        bus.i_cnt_ovf_flg = 1'b1;
        tick();
        bus.i_cnt_ovf_flg = 1'b0;
        check("col_val2", bus.o_cmp_val, 16'h0040);
        check("col_pend2", bus.o_cmp_pending, 0);

        // PWM: ctrl=0x04, cmp=3, counter 0..7
        do_reset();
        bus.i_cnt_data = '0;
        write_ctrl(16'h0004);
        write_cmp(16'h0003);
        bus.i_module_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                bus.i_cnt_data = CNT_W'(k);
                tick();
                check("pwm_pin", bus.o_out_pin, (k < 3) ? 1 : 0);
            end
        end
        check("pwm_flg", bus.o_cmp_flg, 1);
        write_ctrl(16'h000C);
        for (int k = 0; k < 8; k++) begin
            bus.i_cnt_data = CNT_W'(k);
            tick();
            check("pwm_inv_pin", bus.o_out_pin, (k < 3) ? 0 : 1);
        end
        write_ctrl(16'h0004);
        write_cmp(16'h0000);
        for (int k = 0; k < 4; k++) begin
            bus.i_cnt_data = CNT_W'(k);
            tick();
            check("pwm_zero_pin", bus.o_out_pin, 0);
        end
        write_cmp(16'hFFFF);
        bus.i_cnt_data = 16'h0000;
        tick();
        check("pwm_max_0", bus.o_out_pin, 1);
        bus.i_cnt_data = 16'hFFFE;
        tick();
        check("pwm_max_fffe", bus.o_out_pin, 1);
        bus.i_cnt_data = 16'hFFFF;
        tick();
        check("pwm_max_ffff", bus.o_out_pin, 0);

        // Flag collision: event with clear -> set wins; later clear -> 0
        do_reset();
        bus.i_cnt_data = '0;
        write_ctrl(16'h0001);
        write_cmp(16'h0007);
        bus.i_module_en = 1'b1;
        ticks(2);
        check("fc_flg_idle", bus.o_cmp_flg, 0);
        bus.i_cnt_data = 16'h0007;
        bus.i_flg_clr  = 1'b1;
        tick();
        check("fc_flg_set", bus.o_cmp_flg, 1);
        check("fc_pin_set", bus.o_out_pin, 1);
        bus.i_cnt_data = 16'h0008;
        tick();
        bus.i_flg_clr = 1'b0;
        check("fc_flg_clr", bus.o_cmp_flg, 0);

        // Enable and equality: disabled in equality, then enable -> one event
        do_reset();
        bus.i_cnt_data = 16'h0009;
        write_ctrl(16'h0003);
        write_cmp(16'h0009);
        ticks(10);
        check("en_off_pin", bus.o_out_pin, 0);
        check("en_off_flg", bus.o_cmp_flg, 0);
        bus.i_module_en = 1'b1;
        tick();
        check("en_rise_pin", bus.o_out_pin, 1);
        check("en_rise_flg", bus.o_cmp_flg, 1);
        bus.i_flg_clr = 1'b1;
        tick();
        bus.i_flg_clr = 1'b0;
        ticks(5);
        check("en_hold_pin", bus.o_out_pin, 1);
        check("en_hold_flg", bus.o_cmp_flg, 0);
        // Compare write creating equality: event one cycle after active updates
        bus.i_cnt_data = 16'h0004;
        write_cmp(16'h0004);
        check("wr_eq_pin0", bus.o_out_pin, 1);
        tick();
        check("wr_eq_pin1", bus.o_out_pin, 0);
        check("wr_eq_flg", bus.o_cmp_flg, 1);

        // Reset mid-operation with pending and pin high
        do_reset();
        bus.i_cnt_data = '0;
        write_ctrl(16'h0001);
        write_cmp(16'h0002);
        write_ctrl(16'h0011);
        bus.i_module_en = 1'b1;
        bus.i_cnt_data  = 16'h0002;
        tick();
        bus.i_cnt_data  = 16'h0003;
        write_cmp(16'h0050);
        check("mr_pin_pre", bus.o_out_pin, 1);
        check("mr_pend_pre", bus.o_cmp_pending, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mr_pin", bus.o_out_pin, 0);
        check("mr_flg", bus.o_cmp_flg, 0);
        check("mr_pend", bus.o_cmp_pending, 0);
        check("mr_val", bus.o_cmp_val, 0);
        bus.i_cnt_ovf_flg = 1'b1;
        tick();
        bus.i_cnt_ovf_flg = 1'b0;
        check("mr_no_xfer_val", bus.o_cmp_val, 0);
        check("mr_no_xfer_pend", bus.o_cmp_pending, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_compare.md
OUTPUT_COMPARE -- requirements
Module: output_compare

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the counter and compare values.
REQ-002 SHALL have port i_sysclk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port i_sysrst, input, 1, the system reset, which is synchronous and active-low.
REQ-004 SHALL have port i_module_en, input, 1, the channel enable.
REQ-005 SHALL have port i_cnt_data, input, CNT_W, the live counter value.
REQ-006 SHALL have port i_cnt_ovf_flg, input, 1, a one-cycle pulse when the counter wraps.
REQ-007 SHALL have port i_wr_cmp, input, 1, the compare-value write strobe.
REQ-008 SHALL have port i_wr_ctrl, input, 1, the control write strobe.
REQ-009 SHALL have port i_wr_data, input, CNT_W, the write data; control uses bits [4:0].
REQ-010 SHALL have port i_flg_clr, input, 1, which clears the compare flag.
REQ-011 SHALL have port o_out_pin, output, 1, the compare output pin.
REQ-012 SHALL have port o_cmp_flg, output, 1, the sticky compare-match flag.
REQ-013 SHALL have port o_cmp_pending, output, 1, which is high while the shadow register holds an untransferred value.
REQ-014 SHALL have port o_cmp_val, output, CNT_W, the active compare value.

Function
REQ-015 SHALL decode control as follows: [1:0] mode (00 frozen, 01 set, 10 clear, 11 toggle); [2] PWM enable; [3] output polarity invert; [4] preload enable.
REQ-016 SHALL register a control write on the clock edge, with the new control taking effect on the following cycle.
REQ-017 SHALL, with preload=0, load i_wr_data into active compare on the i_wr_cmp edge, with o_cmp_val updating the next cycle.
REQ-018 SHALL, with preload=1, load i_wr_cmp data into shadow and set pending=1; on the cycle after an i_cnt_ovf_flg pulse with pending=1, SHALL copy shadow to active and clear pending.
REQ-019 SHALL handle i_wr_cmp coinciding with i_cnt_ovf_flg (preload=1) by writing new data to shadow, keeping pending=1, and transferring the old shadow value; the new value transfers at the next overflow.
REQ-020 SHALL compute match = (i_cnt_data == active), regardless of counting direction; match_d is the registered match.
REQ-021 SHALL define a match event as match & ~match_d & i_module_en: one event per entry into equality, none while equality persists.
REQ-022 SHALL, in non-PWM mode, update the internal pin state on the edge after a match event: set, clear, toggle, or unchanged (frozen).
REQ-023 SHALL, in PWM mode, update the internal pin state every enabled cycle as (active > i_cnt_data), ignoring mode bits; active=0 gives constant 0, and active=all-ones gives 1 except at count all-ones.
REQ-024 SHALL drive o_out_pin = internal pin state XOR polarity bit (combinational on the registered state).
REQ-025 SHALL set o_cmp_flg on the edge after every match event in all modes, including frozen and PWM.
REQ-026 SHALL clear o_cmp_flg on the edge when i_flg_clr=1; if set and clear occur in the same cycle, set wins.
REQ-027 SHALL, while i_module_en=0, suppress match events, hold the pin state and flag, force match_d to 0, and still accept register writes and shadow transfers.
REQ-028 SHALL, when i_module_en rises while already in equality, produce a match event on the first enabled cycle.
REQ-029 SHALL ensure a compare write that creates equality with the current count produces an event one cycle after active updates.

Reset
REQ-030 SHALL, when i_sysrst=0 at a clock edge, clear active, shadow, control, pin state, o_cmp_flg, o_cmp_pending and match_d to 0, so o_out_pin=0.
REQ-031 SHALL give reset priority over all writes and events in the same cycle, and SHALL abort any pending shadow transfer when reset is asserted mid-operation.

Verification
REQ-032 SHALL cover toggle mode: ctrl=0x03, cmp=0x0005, counter counting 0..9 repeatedly -> o_out_pin toggles once per pass, one cycle after count==5; o_cmp_flg is set.
REQ-033 SHALL cover preload: ctrl=0x11, active=0x0010, write cmp=0x0020 mid-period -> o_cmp_pending=1 and o_cmp_val stays 0x0010 until the cycle after i_cnt_ovf_flg, then becomes 0x0020 with pending=0.
REQ-034 SHALL cover PWM: ctrl=0x04, cmp=0x0003, counter 0..7 wrapping -> pin high for counts 0-2 and low for 3-7 (one-cycle lag); with ctrl=0x0C the waveform is inverted.
REQ-035 SHALL cover flag collision: match event coinciding with i_flg_clr=1 -> o_cmp_flg=1; a later clear with no event -> o_cmp_flg=0.
REQ-036 SHALL cover enable and equality: i_module_en=0 with count held equal to cmp for 10 cycles -> no pin change and no flag; raising i_module_en -> one event; counter held at the value -> no further events.
REQ-037 SHALL cover reset mid-operation: i_sysrst=0 for one cycle with pending=1 and pin=1 -> all outputs 0, and no shadow transfer on the next overflow.
